// File: rtl/seq_divider.sv
// Restoring shift-subtract unsigned divider, one quotient bit per clock, MSB first.
// A three-state FSM (IDLE/RUN/DONE) sequences the operation; all outputs are registered.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] dvd_q;   // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] par_q;   // partial remainder
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             fits;
  logic [WIDTH-1:0] par_d;
  logic [WIDTH-1:0] dvd_d;
  logic             last_iter;

  // The shifted partial remainder can reach 2*divisor-1, so it is kept at WIDTH+1 bits.
  // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
  always_comb begin
    shifted   = {par_q, dvd_q[WIDTH-1]};
    diff      = shifted - {1'b0, dvs_q};
    fits      = (shifted >= {1'b0, dvs_q});
    par_d     = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    dvd_d     = {dvd_q[WIDTH-2:0], fits};
    last_iter = (cnt_q == CW'(WIDTH - 1));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees
  // the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      par_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            dvd_q  <= dividend;
            dvs_q  <= divisor;
            par_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            if (divisor == '0) begin
              quo_q   <= '1;
              rem_q   <= dividend;
              dbz_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              dbz_q   <= 1'b0;
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          par_q <= par_d;
          dvd_q <= dvd_d;
          cnt_q <= cnt_q + CW'(1);
          if (last_iter) begin
            quo_q   <= dvd_d;
            rem_q   <= par_d;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed vector table, multi-cycle corner
// sequences (start while busy, reset mid-run, held results) and a randomized sweep.
module tb_seq_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  int n_checks = 0;
  int n_errors = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at posedge+1 (or any time before the start edge); returns at posedge+1
  // in IDLE, so a following call exercises back-to-back operation.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic edbz, input string tag);
    int n;
    bit seen;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check({tag, " busy after start"}, busy, 1);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) seen = 1'b1;
    end
    check({tag, " latency"}, n, (b == 0) ? 1 : W + 1);
    check({tag, " quotient"}, quotient, eq);
    check({tag, " remainder"}, remainder, er);
    check({tag, " div_by_zero"}, div_by_zero, edbz);
    @(posedge clk);
    #1;
    check({tag, " done one cycle"}, done, 0);
    check({tag, " busy idle"}, busy, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int dones;
    logic [W-1:0] a, b, eq, er;

    vecs[0]  = '{a: 8'd200, b: 8'd7,   q: 8'd28,  r: 8'd4,   dbz: 1'b0};
    vecs[1]  = '{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0,   dbz: 1'b0};
    vecs[2]  = '{a: 8'd5,   b: 8'd9,   q: 8'd0,   r: 8'd5,   dbz: 1'b0};
    vecs[3]  = '{a: 8'd100, b: 8'd0,   q: 8'd255, r: 8'd100, dbz: 1'b1};
    vecs[4]  = '{a: 8'd0,   b: 8'd5,   q: 8'd0,   r: 8'd0,   dbz: 1'b0};
    vecs[5]  = '{a: 8'd255, b: 8'd255, q: 8'd1,   r: 8'd0,   dbz: 1'b0};
    vecs[6]  = '{a: 8'd254, b: 8'd255, q: 8'd0,   r: 8'd254, dbz: 1'b0};
    vecs[7]  = '{a: 8'd255, b: 8'd16,  q: 8'd15,  r: 8'd15,  dbz: 1'b0};
    vecs[8]  = '{a: 8'd128, b: 8'd2,   q: 8'd64,  r: 8'd0,   dbz: 1'b0};
    vecs[9]  = '{a: 8'd0,   b: 8'd0,   q: 8'd255, r: 8'd0,   dbz: 1'b1};
    vecs[10] = '{a: 8'd1,   b: 8'd1,   q: 8'd1,   r: 8'd0,   dbz: 1'b0};

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset quotient", quotient, 0);
    check("reset remainder", remainder, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset div_by_zero", div_by_zero, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    foreach (vecs[i])
      run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dbz, $sformatf("vec%0d", i));

    // Divide-by-zero result and flag stay put through idle cycles, then the flag clears on start.
    run_op(8'd100, 8'd0, 8'd255, 8'd100, 1'b1, "dbz");
    repeat (3) @(posedge clk);
    #1;
    check("dbz held flag", div_by_zero, 1);
    check("dbz held quotient", quotient, 255);
    check("dbz held remainder", remainder, 100);
    dividend = 8'd9;
    divisor  = 8'd3;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("dbz cleared on start", div_by_zero, 0);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("after dbz latency", n, W + 1);
    check("after dbz quotient", quotient, 3);
    @(posedge clk);
    #1;

    // Start with new operands during RUN must be ignored.
    dividend = 8'd200;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    dividend = 8'd50;
    divisor  = 8'd3;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 4;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("busy start latency", n, W + 1);
    check("busy start quotient", quotient, 28);
    check("busy start remainder", remainder, 4);
    dones = 0;
    @(posedge clk);
    repeat (15) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    check("busy start no second done", dones, 0);
    @(posedge clk);
    #1;

    // Reset in the third RUN cycle aborts immediately with no done pulse.
    dividend = 8'd200;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midrun rst quotient", quotient, 0);
    check("midrun rst remainder", remainder, 0);
    check("midrun rst busy", busy, 0);
    check("midrun rst done", done, 0);
    check("midrun rst div_by_zero", div_by_zero, 0);
    dones = 0;
    repeat (2) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    check("midrun rst no done", dones, 0);
    @(posedge clk);
    #1;
    run_op(8'd255, 8'd16, 8'd15, 8'd15, 1'b0, "after rst");

    // Randomized sweep against a reference model, back-to-back.
    for (int i = 0; i < 2000; i++) begin
      a = W'($urandom_range(0, 255));
      b = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom_range(1, 255));
      if (b == 0) begin
        eq = '1;
        er = a;
      end else begin
        eq = a / b;
        er = a % b;
      end
      run_op(a, b, eq, er, (b == 0), "rand");
      if (b != 0) begin
        check("rand identity", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
        check("rand rem below divisor", remainder < b, 1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
